mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction-fetch requester and the data requester of the pipelined datapath.
- Grants the port to one requester per transaction, holds the other in wait, and routes the RAM's returned word back to the granted side.
- Sits between the datapath/cache interface and RAM.
- Data has priority, with a starvation guard for fetch and a watchdog that aborts hung transactions.

Parameters:
STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending before fetch is forced next.
TIMEOUT, 16, cycles a granted transaction may wait without ACCESS/ERROR before abort.

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, asynchronous, active-high (1 = reset)
iREN  in  1  instruction read request
iaddr  in  32  instruction word address
dREN  in  1  data read request
dWEN  in  1  data write request (dREN and dWEN never both 1)
daddr  in  32  data address
dstore  in  32  data write value
ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
ramload  in  32  RAM read data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
iwait  out  1  fetch not complete this cycle
dwait  out  1  data access not complete this cycle
iload  out  32  fetch return word
dload  out  32  data return word
merr  out  1  one-cycle pulse: transaction ended by ERROR or timeout

Behaviour:
- State machine, registered state: IDLE, DATA, INSTR. Counters: starve_cnt (log2(STARVE_MAX+1) bits), wd_cnt (log2(TIMEOUT+1) bits).
- Reset (nRST=1, async):
  - State = IDLE; starve_cnt = 0; wd_cnt = 0; merr = 0.
  - ramREN = 0, ramWEN = 0, ramaddr = 0, ramstore = 0, iload = 0, dload = 0.
  - iwait = iREN; dwait = dREN|dWEN (all requests wait).
- IDLE:
  - RAM enables 0, ramaddr = 0.
  - If (dREN|dWEN) and not (iREN and starve_cnt == STARVE_MAX): next state DATA.
  - Else if iREN: next state INSTR.
  - Otherwise stay in IDLE.
- DATA: ramREN = dREN, ramWEN = dWEN, ramaddr = daddr, ramstore = dstore.
- INSTR: ramREN = 1, ramWEN = 0, ramaddr = iaddr, ramstore = 0.
- Transaction completion, in the granted state:
  - ramstate == ACCESS: granted wait deasserted combinationally that cycle; dload/iload = ramload that cycle (0 otherwise). Next state IDLE.
  - ramstate == ERROR, or wd_cnt == TIMEOUT-1 without ACCESS: transaction ends. Granted wait stays 1, merr = 1 the following cycle (registered), next state IDLE. The requester re-arbitrates from IDLE.
  - Requester drops its request mid-transaction: RAM enables fall combinationally, next state IDLE, no merr.
- Wait signals:
  - iwait = iREN & !(state==INSTR & ramstate==ACCESS).
  - dwait = (dREN|dWEN) & !(state==DATA & ramstate==ACCESS).
- Latency:
  - Request seen in IDLE at cycle n; RAM driven from cycle n+1.
  - Minimum fetch latency 2 cycles (RAM returns ACCESS in the first granted cycle).
  - Back-to-back transactions always pass through one IDLE cycle.
- wd_cnt:
  - Clears on entering DATA/INSTR; increments each granted cycle without ACCESS/ERROR.
  - Saturates at TIMEOUT-1.
- starve_cnt:
  - Increments on each DATA completion while iREN = 1; saturates at STARVE_MAX.
  - Clears on INSTR completion or whenever iREN = 0 in IDLE.
- Simultaneous iREN and dREN/dWEN in IDLE: DATA wins unless starve_cnt == STARVE_MAX.
- Reset mid-transaction: state returns to IDLE immediately, RAM enables drop asynchronously, counters clear.

Test Plan:
1. Fetch-only: iREN=1, iaddr=0x40, RAM returns ACCESS with ramload=0x8C220004 on its first cycle -> ramREN=1/ramaddr=0x40 in cycle 2, iwait=0 and iload=0x8C220004 that cycle, ramREN=0 in cycle 3.
2. Write priority: iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF) together in IDLE -> DATA granted first (ramWEN=1, ramstore=0xDEADBEEF, iwait=1); after ACCESS and one IDLE cycle, INSTR granted.
3. Starvation guard (STARVE_MAX=4): iREN held, dREN re-asserted continuously -> exactly 4 data completions, then INSTR granted while dREN=1; starve_cnt returns to 0.
4. Timeout (TIMEOUT=16): dREN=1, ramstate held BUSY -> ramREN drops after 16 granted cycles, merr=1 for one cycle, dwait stays 1, DATA re-granted after IDLE.
5. ERROR and abort: ramstate=ERROR in INSTR -> merr pulse, IDLE next. Separately, dREN dropped mid-DATA -> ramREN=0 the same cycle, IDLE next, no merr.
6. Async reset mid-DATA: nRST=1 between clock edges -> ramREN/ramWEN=0 immediately, state IDLE, counters 0; after release, a pending request re-arbitrates normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares the single RAM port between the instruction-fetch requester and the
// data requester of the pipelined datapath. One side is granted per
// transaction and the other side waits. Data normally wins, but a fetch that
// has watched STARVE_MAX data transactions complete is forced through next.
// A watchdog aborts any granted transaction that sees neither ACCESS nor
// ERROR for TIMEOUT cycles.
//
// Ports
//   CLK       clock, rising edge
//   nRST      asynchronous reset, active-high (1 = reset)
//   iREN      instruction read request
//   iaddr     instruction word address
//   dREN      data read request
//   dWEN      data write request (never asserted together with dREN)
//   daddr     data address
//   dstore    data write value
//   ramstate  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//   ramload   RAM read data
//   ramREN    RAM read enable
//   ramWEN    RAM write enable
//   ramaddr   RAM address
//   ramstore  RAM write data
//   iwait     fetch not complete this cycle
//   dwait     data access not complete this cycle
//   iload     fetch return word (valid while iwait is low)
//   dload     data return word (valid while dwait is low)
//   merr      one-cycle pulse after a transaction ends by ERROR or timeout

module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        merr
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [WW-1:0] WD_LIM     = WW'(TIMEOUT - 1);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    INSTR
  } state_t;

  state_t        state, next_state;
  logic [SW-1:0] starve_cnt, starve_next;
  logic [WW-1:0] wd_cnt, wd_next;
  logic          merr_next;
  logic          dreq;
  logic          access;
  logic          error;

  assign dreq   = dREN | dWEN;
  assign access = (ramstate == RS_ACCESS);
  assign error  = (ramstate == RS_ERROR);

  // Wait flags drop only in the cycle the granted side sees ACCESS, so a
  // requester that was aborted keeps waiting and simply re-arbitrates.
  assign iwait = iREN & ~((state == INSTR) & access);
  assign dwait = dreq & ~((state == DATA) & access);

  // State, counters and the error pulse. Reset is asynchronous so the RAM
  // enables (decoded from state) drop the moment reset is asserted.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wd_cnt     <= '0;
      merr       <= 1'b0;
    end else begin
      state      <= next_state;
      starve_cnt <= starve_next;
      wd_cnt     <= wd_next;
      merr       <= merr_next;
    end
  end

  // Arbitration, RAM port drive and transaction completion. Every grant
  // returns to IDLE when it ends, so back-to-back transactions always see
  // one IDLE cycle in which the other side can win.
  always_comb begin
    next_state  = state;
    starve_next = starve_cnt;
    wd_next     = wd_cnt;
    merr_next   = 1'b0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iload       = '0;
    dload       = '0;

    case (state)
      IDLE: begin
        // No fetch waiting means nobody is being starved.
        if (!iREN) begin
          starve_next = '0;
        end
        if (dreq && !(iREN && (starve_cnt == STARVE_LIM))) begin
          next_state = DATA;
          wd_next    = '0;
        end else if (iREN) begin
          next_state = INSTR;
          wd_next    = '0;
        end
      end

      DATA: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        // A withdrawn request is a quiet abort: the enables already follow
        // the request lines, so just go home without flagging an error.
        if (!dreq) begin
          next_state = IDLE;
        end else if (access) begin
          dload      = ramload;
          next_state = IDLE;
          if (iREN && (starve_cnt != STARVE_LIM)) begin
            starve_next = starve_cnt + 1'b1;
          end
        end else if (error || (wd_cnt == WD_LIM)) begin
          merr_next  = 1'b1;
          next_state = IDLE;
        end else begin
          // The abort branch above stops the count at WD_LIM.
          wd_next = wd_cnt + 1'b1;
        end
      end

      INSTR: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          next_state = IDLE;
        end else if (access) begin
          iload       = ramload;
          next_state  = IDLE;
          starve_next = '0;
        end else if (error || (wd_cnt == WD_LIM)) begin
          merr_next  = 1'b1;
          next_state = IDLE;
        end else begin
          wd_next = wd_cnt + 1'b1;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Stimulus pushes the transactions it
// expects to complete into a scoreboard queue; a monitor pops one entry each
// time the arbiter reports a completed fetch, completed data access or an
// merr pulse. Cycle-exact behaviour (grant timing, enables, waits) is also
// checked directly from the stimulus thread.

module tb_mem_arbiter;

  localparam int K_FETCH  = 0;
  localparam int K_DREAD  = 1;
  localparam int K_DWRITE = 2;
  localparam int K_MERR   = 3;

  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [1:0]  ramstate;
  logic [31:0] ramload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        merr;

  logic [1:0]  ramMode;
  exp_t        expQ[$];
  int          checks   = 0;
  int          failures = 0;

  mem_arbiter #(
    .STARVE_MAX(4),
    .TIMEOUT   (16)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .ramstate(ramstate),
    .ramload (ramload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .iwait   (iwait),
    .dwait   (dwait),
    .iload   (iload),
    .dload   (dload),
    .merr    (merr)
  );

  // Free-running clock, period 10.
  always #5 CLK = ~CLK;

  // RAM contents: one fixed instruction word, everything else a simple
  // address pattern so expected read data can be worked out by hand.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C220004;
    return a ^ 32'hA5A50000;
  endfunction

  // RAM model: answers with the selected status whenever it is enabled.
  always_comb begin
    ramstate = (ramREN | ramWEN) ? ramMode : 2'd0;
    ramload  = memWord(ramaddr);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic i, input logic [31:0] ia,
                               input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] ds);
    iREN   = i;
    iaddr  = ia;
    dREN   = dr;
    dWEN   = dw;
    daddr  = da;
    dstore = ds;
  endtask

  task automatic nextCycle;
    @(posedge CLK);
    #1;
  endtask

  task automatic popCheck(input int kind);
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL sb_unexpected: got event kind %0d, expected no event", kind);
    end else begin
      e = expQ.pop_front();
      checkOutput("sb_kind", kind, e.kind);
      case (e.kind)
        K_FETCH: begin
          checkOutput("sb_fetch_addr", ramaddr, e.addr);
          checkOutput("sb_iload", iload, e.data);
        end
        K_DREAD: begin
          checkOutput("sb_read_addr", ramaddr, e.addr);
          checkOutput("sb_dload", dload, e.data);
        end
        K_DWRITE: begin
          checkOutput("sb_write_addr", ramaddr, e.addr);
          checkOutput("sb_ramstore", ramstore, e.data);
          checkOutput("sb_ramWEN", ramWEN, 1);
        end
        default: begin
        end
      endcase
    end
  endtask

  // Monitor: completions are the cycles where a requester's wait drops;
  // merr pulses are reported separately.
  initial begin
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        if (iREN && !iwait) popCheck(K_FETCH);
        if ((dREN | dWEN) && !dwait) popCheck(dWEN ? K_DWRITE : K_DREAD);
        if (merr) popCheck(K_MERR);
      end
    end
  end

  // Hard stop in case the stimulus thread ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no end of stimulus, expected end before time limit");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Directed stimulus.
  initial begin
    ramMode = RS_ACCESS;
    nRST    = 1'b1;
    applyStimulus(1, 32'h0, 0, 1, 32'h0, 32'h0);

    // Reset: everything quiet, all requests wait.
    @(negedge CLK);
    checkOutput("rst_ramREN", ramREN, 0);
    checkOutput("rst_ramWEN", ramWEN, 0);
    checkOutput("rst_ramaddr", ramaddr, 0);
    checkOutput("rst_ramstore", ramstore, 0);
    checkOutput("rst_iload", iload, 0);
    checkOutput("rst_dload", dload, 0);
    checkOutput("rst_merr", merr, 0);
    checkOutput("rst_iwait", iwait, 1);
    checkOutput("rst_dwait", dwait, 1);
    nextCycle;
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0);
    nextCycle;
    nRST = 1'b0;

    // Fetch-only, RAM answers in the first granted cycle.
    nextCycle;
    applyStimulus(1, 32'h40, 0, 0, 32'h0, 32'h0);
    expQ.push_back('{K_FETCH, 32'h40, 32'h8C220004});
    @(negedge CLK);
    checkOutput("t1_idle_ramREN", ramREN, 0);
    checkOutput("t1_idle_iwait", iwait, 1);
    nextCycle;
    @(negedge CLK);
    checkOutput("t1_ramREN", ramREN, 1);
    checkOutput("t1_ramaddr", ramaddr, 32'h40);
    checkOutput("t1_iwait", iwait, 0);
    checkOutput("t1_iload", iload, 32'h8C220004);
    nextCycle;
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge CLK);
    checkOutput("t1_after_ramREN", ramREN, 0);

    // Write beats a simultaneous fetch, then the fetch follows.
    nextCycle;
    applyStimulus(1, 32'h44, 0, 1, 32'h100, 32'hDEADBEEF);
    expQ.push_back('{K_DWRITE, 32'h100, 32'hDEADBEEF});
    expQ.push_back('{K_FETCH, 32'h44, 32'hA5A50044});
    @(negedge CLK);
    checkOutput("t2_idle_ramWEN", ramWEN, 0);
    nextCycle;
    @(negedge CLK);
    checkOutput("t2_ramWEN", ramWEN, 1);
    checkOutput("t2_ramaddr", ramaddr, 32'h100);
    checkOutput("t2_ramstore", ramstore, 32'hDEADBEEF);
    checkOutput("t2_iwait", iwait, 1);
    checkOutput("t2_dwait", dwait, 0);
    nextCycle;
    applyStimulus(1, 32'h44, 0, 0, 32'h0, 32'h0);
    @(negedge CLK);
    checkOutput("t2_gap_ramREN", ramREN, 0);
    checkOutput("t2_gap_iwait", iwait, 1);
    nextCycle;
    @(negedge CLK);
    checkOutput("t2_fetch_ramREN", ramREN, 1);
    checkOutput("t2_fetch_ramaddr", ramaddr, 32'h44);
    checkOutput("t2_fetch_iwait", iwait, 0);
    nextCycle;
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0);

    // Starvation guard: four data reads, then the fetch, then data wins again.
    nextCycle;
    applyStimulus(1, 32'h48, 1, 0, 32'h200, 32'h0);
    for (int k = 0; k < 4; k++) expQ.push_back('{K_DREAD, 32'h200, 32'hA5A50200});
    expQ.push_back('{K_FETCH, 32'h48, 32'hA5A50048});
    expQ.push_back('{K_DREAD, 32'h200, 32'hA5A50200});
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      checkOutput("t3_idle_ramREN", ramREN, 0);
      nextCycle;
      @(negedge CLK);
      checkOutput("t3_data_ramaddr", ramaddr, 32'h200);
      checkOutput("t3_data_iwait", iwait, 1);
      nextCycle;
    end
    @(negedge CLK);
    checkOutput("t3_gap_ramREN", ramREN, 0);
    nextCycle;
    @(negedge CLK);
    checkOutput("t3_forced_ramREN", ramREN, 1);
    checkOutput("t3_forced_ramaddr", ramaddr, 32'h48);
    checkOutput("t3_forced_iwait", iwait, 0);
    checkOutput("t3_forced_dwait", dwait, 1);
    nextCycle;
    @(negedge CLK);
    checkOutput("t3_gap2_ramREN", ramREN, 0);
    nextCycle;
    @(negedge CLK);
    checkOutput("t3_regrant_ramaddr", ramaddr, 32'h200);
    checkOutput("t3_regrant_iwait", iwait, 1);
    nextCycle;
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0);

    // Watchdog: 16 granted BUSY cycles, abort, merr, then re-grant.
    nextCycle;
    ramMode = RS_BUSY;
    applyStimulus(0, 32'h0, 1, 0, 32'h300, 32'h0);
    expQ.push_back('{K_MERR, 32'h0, 32'h0});
    expQ.push_back('{K_DREAD, 32'h300, 32'hA5A50300});
    @(negedge CLK);
    checkOutput("t4_idle_ramREN", ramREN, 0);
    for (int k = 1; k <= 16; k++) begin
      nextCycle;
      @(negedge CLK);
      checkOutput("t4_busy_ramREN", ramREN, 1);
      checkOutput("t4_busy_merr", merr, 0);
    end
    nextCycle;
    @(negedge CLK);
    checkOutput("t4_abort_ramREN", ramREN, 0);
    checkOutput("t4_abort_merr", merr, 1);
    checkOutput("t4_abort_dwait", dwait, 1);
    nextCycle;
    ramMode = RS_ACCESS;
    @(negedge CLK);
    checkOutput("t4_regrant_ramREN", ramREN, 1);
    checkOutput("t4_regrant_merr", merr, 0);
    checkOutput("t4_regrant_dload", dload, 32'hA5A50300);
    nextCycle;
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0);

    // ERROR during a fetch.
    nextCycle;
    ramMode = RS_ERROR;
    applyStimulus(1, 32'h50, 0, 0, 32'h0, 32'h0);
    expQ.push_back('{K_MERR, 32'h0, 32'h0});
    @(negedge CLK);
    nextCycle;
    @(negedge CLK);
    checkOutput("t5_err_ramREN", ramREN, 1);
    checkOutput("t5_err_ramaddr", ramaddr, 32'h50);
    checkOutput("t5_err_iwait", iwait, 1);
    checkOutput("t5_err_merr", merr, 0);
    nextCycle;
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0);
    ramMode = RS_ACCESS;
    @(negedge CLK);
    checkOutput("t5_pulse_merr", merr, 1);
    checkOutput("t5_pulse_ramREN", ramREN, 0);
    nextCycle;
    @(negedge CLK);
    checkOutput("t5_pulse_end_merr", merr, 0);

    // Data request withdrawn mid-transaction: quiet abort.
    nextCycle;
    ramMode = RS_BUSY;
    applyStimulus(0, 32'h0, 1, 0, 32'h304, 32'h0);
    @(negedge CLK);
    nextCycle;
    @(negedge CLK);
    checkOutput("t5_drop_granted_ramREN", ramREN, 1);
    checkOutput("t5_drop_granted_ramaddr", ramaddr, 32'h304);
    nextCycle;
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge CLK);
    checkOutput("t5_drop_ramREN", ramREN, 0);
    checkOutput("t5_drop_merr", merr, 0);
    checkOutput("t5_drop_dwait", dwait, 0);
    nextCycle;
    @(negedge CLK);
    checkOutput("t5_drop_after_merr", merr, 0);
    ramMode = RS_ACCESS;

    // Asynchronous reset in the middle of a data write.
    nextCycle;
    ramMode = RS_BUSY;
    applyStimulus(0, 32'h0, 0, 1, 32'h308, 32'h12345678);
    expQ.push_back('{K_DWRITE, 32'h308, 32'h12345678});
    @(negedge CLK);
    nextCycle;
    @(negedge CLK);
    checkOutput("t6_pre_ramWEN", ramWEN, 1);
    #2;
    nRST = 1'b1;
    #1;
    checkOutput("t6_async_ramWEN", ramWEN, 0);
    checkOutput("t6_async_ramREN", ramREN, 0);
    checkOutput("t6_async_dwait", dwait, 1);
    nextCycle;
    checkOutput("t6_held_ramWEN", ramWEN, 0);
    checkOutput("t6_held_merr", merr, 0);
    ramMode = RS_ACCESS;
    @(negedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("t6_release_ramWEN", ramWEN, 0);
    nextCycle;
    @(negedge CLK);
    checkOutput("t6_regrant_ramWEN", ramWEN, 1);
    checkOutput("t6_regrant_ramstore", ramstore, 32'h12345678);
    checkOutput("t6_regrant_dwait", dwait, 0);
    nextCycle;
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0);

    nextCycle;
    nextCycle;
    checkOutput("sb_queue_empty", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
